// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: AR/R handshake bundle between the CPU masters, the slaves and the read arbiter
interface axi_rd_arbiter_if #(parameter int NS = 7);
  logic [1:0]    m_arvalid;
  logic [31:0]   m_araddr0;
  logic [31:0]   m_araddr1;
  logic [1:0]    m_arready;
  logic [NS-1:0] s_arvalid;
  logic [NS-1:0] s_arready;
  logic [NS-1:0] s_rvalid;
  logic [NS-1:0] s_rlast;
  logic [NS-1:0] s_rready;
  logic [1:0]    m_rvalid;
  logic [1:0]    m_rlast;
  logic [1:0]    m_rready;
  logic          sel_master;
  logic [2:0]    sel_slave;
  logic          busy;
  modport slave (
    input  m_arvalid, m_araddr0, m_araddr1, s_arready, s_rvalid, s_rlast, m_rready,
    output m_arready, s_arvalid, s_rready, m_rvalid, m_rlast, sel_master, sel_slave, busy
  );
  modport master (
    output m_arvalid, m_araddr0, m_araddr1, s_arready, s_rvalid, s_rlast, m_rready,
    input  m_arready, s_arvalid, s_rready, m_rvalid, m_rlast, sel_master, sel_slave, busy
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin read-channel arbiter that grants one AR request and routes handshakes until RLAST
module axi_rd_arbiter #(parameter int NS = 7) (
  input logic clk,
  input logic rst,
  axi_rd_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2;
  logic [1:0]  state;
  logic        last_grant;
  logic        gm;
  logic [31:0] addr;
  logic        arv, ars, rv, rl, rr;
  function automatic logic [2:0] decode(input logic [31:0] a);
    return a[31:14] == 18'h0     ? 3'd0 :
           a[31:16] == 16'h1     ? 3'd1 :
           a[31:16] == 16'h2     ? 3'd2 :
           a[31:21] == 11'h100   ? 3'd3 :
           a[31:10] == 22'h40000 ? 3'd4 :
           a[31:10] == 22'h40040 ? 3'd5 : 3'(NS-1);
  endfunction
  always_comb begin
    gm   = &bus.m_arvalid ? ~last_grant : bus.m_arvalid[1];
    addr = gm ? bus.m_araddr1 : bus.m_araddr0;
    arv  = bus.m_arvalid[bus.sel_master];
    ars  = bus.s_arready[bus.sel_slave];
    rv   = bus.s_rvalid[bus.sel_slave];
    rl   = bus.s_rlast[bus.sel_slave];
    rr   = bus.m_rready[bus.sel_master];
    bus.s_arvalid = state == ADDR ? NS'(arv) << bus.sel_slave : '0;
    bus.m_arready = state == ADDR ? 2'(ars) << bus.sel_master : 2'b0;
    bus.m_rvalid  = state == DATA ? 2'(rv) << bus.sel_master : 2'b0;
    bus.m_rlast   = state == DATA ? 2'(rv & rl) << bus.sel_master : 2'b0;
    bus.s_rready  = state == DATA ? NS'(rr) << bus.sel_slave : '0;
  end
  // decode is latched at grant so later address changes cannot retarget the path
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      bus.sel_master <= 1'b0;
      bus.sel_slave  <= 3'd0;
      bus.busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (|bus.m_arvalid) begin
          bus.sel_master <= gm;
          bus.sel_slave  <= decode(addr);
          bus.busy       <= 1'b1;
          state          <= ADDR;
        end
        ADDR: if (arv && ars) state <= DATA;
        DATA: if (rv && rr && rl) begin
          last_grant <= bus.sel_master;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed-vector bench for the round-robin AXI read arbiter
module tb_axi_rd_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   beats1 = 0;
  int   base;
  axi_rd_arbiter_if #(.NS(7)) bus();
  axi_rd_arbiter #(.NS(7)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.m_rvalid[1] && bus.m_rready[1]) beats1++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    bus.m_arvalid = '0; bus.m_araddr0 = '0; bus.m_araddr1 = '0;
    bus.s_arready = '0; bus.s_rvalid = '0; bus.s_rlast = '0; bus.m_rready = '0;
  endtask
  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    step();
  endtask
  task automatic zero_outputs(input string tag);
    chk({tag, "_s_arvalid"}, 32'(bus.s_arvalid), 0);
    chk({tag, "_m_arready"}, 32'(bus.m_arready), 0);
    chk({tag, "_m_rvalid"}, 32'(bus.m_rvalid), 0);
    chk({tag, "_m_rlast"}, 32'(bus.m_rlast), 0);
    chk({tag, "_s_rready"}, 32'(bus.s_rready), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask
  // called one cycle after the grant edge; completes the AR handshake
  task automatic ar_phase(input int m, input int s);
    chk("grant_busy", 32'(bus.busy), 1);
    chk("grant_sel_master", 32'(bus.sel_master), m);
    chk("grant_sel_slave", 32'(bus.sel_slave), s);
    chk("ar_s_arvalid", 32'(bus.s_arvalid), 32'(7'(1) << s));
    bus.s_arready = 7'(1) << s;
    #1;
    chk("ar_m_arready", 32'(bus.m_arready), 32'(2'(1) << m));
    step();
    bus.s_arready = '0;
    bus.m_arvalid[m] = 1'b0;
    #1;
    chk("data_s_arvalid", 32'(bus.s_arvalid), 0);
  endtask
  task automatic one_beat(input int m, input int s);
    bus.s_rvalid = 7'(1) << s;
    bus.s_rlast  = 7'(1) << s;
    bus.m_rready = 2'(1) << m;
    #1;
    chk("beat_m_rvalid", 32'(bus.m_rvalid), 32'(2'(1) << m));
    chk("beat_m_rlast", 32'(bus.m_rlast), 32'(2'(1) << m));
    chk("beat_s_rready", 32'(bus.s_rready), 32'(7'(1) << s));
    step();
    bus.s_rvalid = '0; bus.s_rlast = '0; bus.m_rready = '0;
    #1;
    chk("release_busy", 32'(bus.busy), 0);
  endtask
  initial begin
    clear_inputs();
    #1;
    zero_outputs("reset");
    chk("reset_sel_master", 32'(bus.sel_master), 0);
    chk("reset_sel_slave", 32'(bus.sel_slave), 0);
    do_reset();
    // single M0 ROM read
    bus.m_arvalid = 2'b01; bus.m_araddr0 = 32'h0000_0010;
    #1;
    chk("idle_s_arvalid", 32'(bus.s_arvalid), 0);
    step();
    ar_phase(0, 0);
    one_beat(0, 0);
    chk("idle_m_rvalid", 32'(bus.m_rvalid), 0);
    // simultaneous requests after reset: M0 first, then M1, then M0 again
    do_reset();
    bus.m_arvalid = 2'b11; bus.m_araddr0 = 32'h0000_0100; bus.m_araddr1 = 32'h0002_0004;
    step();
    ar_phase(0, 0);
    one_beat(0, 0);
    chk("gap_s_arvalid", 32'(bus.s_arvalid), 0);
    step();
    ar_phase(1, 2);
    one_beat(1, 2);
    bus.m_arvalid = 2'b11; bus.m_araddr1 = 32'h2000_0100;
    step();
    ar_phase(0, 0);
    one_beat(0, 0);
    step();
    // M1 DRAM burst of 4 with 3-cycle RVALID gaps
    ar_phase(1, 3);
    base = beats1;
    bus.m_rready = 2'b10;
    for (int b = 0; b < 4; b++) begin
      bus.s_rvalid = 7'b0001000;
      bus.s_rlast  = b == 3 ? 7'b0001000 : 7'b0;
      #1;
      chk("burst_m_rvalid", 32'(bus.m_rvalid), 2);
      chk("burst_m_rlast", 32'(bus.m_rlast), b == 3 ? 2 : 0);
      step();
      bus.s_rvalid = '0; bus.s_rlast = '0;
      if (b < 3) begin
        for (int g = 0; g < 3; g++) begin
          #1;
          chk("gap_m_rvalid", 32'(bus.m_rvalid), 0);
          chk("gap_busy", 32'(bus.busy), 1);
          step();
        end
      end
    end
    bus.m_rready = '0;
    chk("burst_beats", 32'(beats1 - base), 4);
    chk("burst_release", 32'(bus.busy), 0);
    // unmapped address hits the default slave
    bus.m_arvalid = 2'b01; bus.m_araddr0 = 32'h3000_0000;
    step();
    ar_phase(0, 6);
    one_beat(0, 6);
    // M1 backpressure for 5 cycles; decode stays latched despite address change
    bus.m_arvalid = 2'b10; bus.m_araddr1 = 32'h0001_0000;
    step();
    bus.m_araddr1 = 32'h0000_0000;
    ar_phase(1, 1);
    bus.s_rvalid = 7'b0000010; bus.s_rlast = 7'b0000010; bus.m_rready = 2'b00;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_s_rready", 32'(bus.s_rready), 0);
      chk("bp_m_rvalid", 32'(bus.m_rvalid), 2);
      chk("bp_busy", 32'(bus.busy), 1);
      step();
    end
    bus.m_rready = 2'b10;
    #1;
    chk("bp_release_s_rready", 32'(bus.s_rready), 2);
    step();
    bus.s_rvalid = '0; bus.s_rlast = '0; bus.m_rready = '0;
    #1;
    chk("bp_busy_end", 32'(bus.busy), 0);
    // asynchronous reset in DATA
    bus.m_arvalid = 2'b10; bus.m_araddr1 = 32'h0002_0000;
    step();
    ar_phase(1, 2);
    bus.s_rvalid = 7'b0000100; bus.m_rready = 2'b10;
    #1;
    chk("pre_rst_m_rvalid", 32'(bus.m_rvalid), 2);
    #1 rst = 1'b0;
    #1;
    zero_outputs("async_rst");
    chk("async_rst_sel_slave", 32'(bus.sel_slave), 0);
    chk("async_rst_sel_master", 32'(bus.sel_master), 0);
    clear_inputs();
    @(posedge clk);
    #2 rst = 1'b1;
    bus.m_arvalid = 2'b10; bus.m_araddr1 = 32'h1001_03FC;
    step();
    ar_phase(1, 5);
    one_beat(1, 5);
    bus.m_arvalid = 2'b01; bus.m_araddr0 = 32'h1000_0000;
    step();
    ar_phase(0, 4);
    one_beat(0, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Read-channel arbiter and router for the AXI interconnect. Shares the slave read paths among the two CPU masters: M0 (instruction fetch) and M1 (data). The slaves are S0 ROM, S1 IM1, S2 DM1, S3 DRAM, S4 sensor, S5 WDT, and S6 the default (error) slave. The block grants one AR request at a time with round-robin priority, decodes the target slave, and routes handshakes. It holds the path until the final R beat, then releases. Data, ID and address buses are muxed outside the block using `sel_master`/`sel_slave`.

## Interface
- `NS`, 7, number of slave ports including the default slave at index `NS-1`
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; the block has one clock, and reset is asynchronous and active-low
- `m_arvalid`  in  2  ARVALID from M0 (bit 0) and M1 (bit 1)
- `m_araddr0`, `m_araddr1`  in  32  ARADDR of M0 and M1
- `m_arready`  out  2  ARREADY to M0/M1
- `s_arvalid`  out  NS  one-hot ARVALID to the slaves
- `s_arready`  in  NS  ARREADY from the slaves
- `s_rvalid`, `s_rlast`  in  NS  RVALID/RLAST from the slaves
- `s_rready`  out  NS  RREADY to the slaves
- `m_rvalid`, `m_rlast`  out  2  routed RVALID/RLAST to M0/M1
- `m_rready`  in  2  RREADY from M0/M1
- `sel_master`  out  1  granted master index, for external AR/R bus muxes
- `sel_slave`  out  3  granted slave index
- `busy`  out  1  high while a grant is held

## Operation
- Address map, decoded on bits [31:0]:
  - S0: 0x0000_0000–0x0000_3FFF
  - S1: 0x0001_0000–0x0001_FFFF
  - S2: 0x0002_0000–0x0002_FFFF
  - S3: 0x2000_0000–0x201F_FFFF
  - S4: 0x1000_0000–0x1000_03FF
  - S5: 0x1001_0000–0x1001_03FF
  - anything else: S6
- FSM states: IDLE, ADDR, DATA.
- IDLE transitions:
  - No valid request: stay in IDLE.
  - Exactly one `m_arvalid` set: grant that master.
  - Both set: grant the master that is not `last_grant`.
  - On grant: register `sel_master`, register `sel_slave` from the granted master's address, set `busy`, go to ADDR.
- ADDR state:
  - `s_arvalid[sel_slave] = m_arvalid[sel_master]`.
  - `m_arready[sel_master] = s_arready[sel_slave]`.
  - All other bits are 0.
  - On the AR handshake (both high), go to DATA.
- DATA state:
  - `m_rvalid[sel_master] = s_rvalid[sel_slave]`.
  - `m_rlast[sel_master] = s_rvalid[sel_slave] & s_rlast[sel_slave]`.
  - `s_rready[sel_slave] = m_rready[sel_master]`.
  - All other bits are 0.
  - On `rvalid & rready & rlast`: set `last_grant <= sel_master`, clear `busy`, go to IDLE.
- In IDLE, all routed handshake outputs are 0. No beat is ever forwarded to a non-granted master or slave.
- Grant is not preemptible: a request from the other master while busy waits. Burst length is not checked; only RLAST ends the transaction.
- A master that deasserts ARVALID in ADDR (an AXI violation) keeps the grant and the FSM stays in ADDR. There is no timeout.
- The decode is latched at grant, so address changes after the grant do not alter `sel_slave`.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - state = IDLE
  - `sel_master` = 0, `sel_slave` = 0, `busy` = 0
  - `last_grant` = 1, so M0 wins the first tie
  - all `*valid`/`*ready`/`*last` outputs = 0
- Grant latency: request seen in IDLE at cycle N gives `busy`=1 and `s_arvalid` high in cycle N+1.
- AR and R routing is combinational through registered selects: zero added latency per handshake.
- Release: a last beat accepted at cycle M gives IDLE at M+1, and a new grant is visible at M+2. There is a minimum of one IDLE cycle between transactions.
- Reset asserted mid-transaction: the FSM drops to IDLE immediately, all routed outputs go to 0, and no partial state is retained.
- Fairness: under continuous requests from both masters, grants strictly alternate M0, M1, M0, …

## Test plan
- Reset, then M0 ARADDR 0x0000_0010 with ARVALID: `sel_slave`=0 and `s_arvalid`=0000001 the next cycle; ROM ARREADY gives AR handshake; a single beat with RLAST returns the FSM to IDLE 1 cycle later.
- M0 and M1 request in the same cycle after reset, M1 ARADDR 0x0002_0004 → M0 granted first. M1 is granted after M0's last beat, with `sel_slave`=2; the next simultaneous pair goes to M0 again (alternation).
- M1 reads 0x2000_0100 from the DRAM with a 4-beat burst and slave RVALID gapped 3 cycles → exactly 4 `m_rvalid[1]` pulses, `m_rlast[1]` on the 4th only, and `busy` held throughout.
- Read of 0x3000_0000 → `sel_slave`=6, `s_arvalid`=1000000; the default slave's DECERR beat reaches the requester.
- M1 `m_rready`=0 for 5 cycles during DATA → `s_rready`=0 for those cycles; no beat is lost and `m_rvalid` stays asserted.
- `rst` pulsed low in the DATA state → all outputs 0 asynchronously; after release, a fresh M1-only request is granted normally.
